// File: rtl/dmem_pkg.sv
// Shared types and strobe helpers for the data-memory responder.
// The strobe check in strb_legal() is only applied when DMEM_ERR_EN is defined.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    // Naturally aligned byte, halfword or word lanes only.
    function automatic logic strb_legal(input logic [3:0] strb);
        case (strb)
            STRB_B, 4'b0010, 4'b0100, 4'b1000,
            STRB_H, 4'b1100, STRB_W: strb_legal = 1'b1;
            default:                 strb_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Valid/ready request and response channels of the data-memory port.
interface dmem_responder_if #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [3:0]            req_wstrb;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_wstrb, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_wstrb, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_byte_ram.sv
// Word-indexed RAM built from four byte-lane arrays with per-lane write enables
// and a registered read of the addressed word. Contents are not reset.
module dmem_byte_ram #(
    parameter int unsigned IDX_W = 7
) (
    input  logic             clk,
    input  logic [3:0]       we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);
    localparam int unsigned Words = 1 << IDX_W;

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [Words];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (we[l]) begin
                mem[idx] <= wdata[8*l +: 8];
            end
            if (re) begin
                rd_q <= mem[idx];
            end
        end

        assign rdata[8*l +: 8] = rd_q;
    end

endmodule

// File: rtl/dmem_responder.sv
// Byte-addressable data-memory responder with programmable wait states.
// Optional macro DMEM_ERR_EN: reject misaligned store strobes with rsp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DM_ADDRESS  = 9,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_STATES = 1
) (
    input logic             clk,
    input logic             rst_n,
    dmem_responder_if.slave bus
);
    localparam int unsigned IdxW     = DM_ADDRESS - 2;
    localparam bit          Direct   = (WAIT_STATES == 0);
    localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

    dmem_state_t       state;
    logic [3:0]        cnt;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_load_q;
    logic              rsp_err_q;
    logic              we_q;
    logic [3:0]        wstrb_q;
    logic [IdxW-1:0]   idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;

    logic              accept;
    logic              acc_err;
    logic              commit;
    logic              c_we;
    logic [3:0]        c_strb;
    logic [IdxW-1:0]   c_idx;
    logic [DATA_W-1:0] c_wdata;
    logic              c_err;
    logic [3:0]        ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_addr;

    assign accept      = (state == IDLE) && bus.req_valid && req_ready_q;
    assign unused_addr = ^bus.req_addr[1:0];

`ifdef DMEM_ERR_EN
    assign acc_err = bus.req_we && !strb_legal(bus.req_wstrb);
`else
    assign acc_err = 1'b0;
`endif

    // With no wait states the commit happens on the accept edge itself,
    // so the RAM is driven straight from the request rather than the latches.
    always_comb begin
        if (Direct) begin
            commit  = accept;
            c_we    = bus.req_we;
            c_strb  = bus.req_wstrb;
            c_idx   = bus.req_addr[DM_ADDRESS-1:2];
            c_wdata = bus.req_wdata;
            c_err   = acc_err;
        end else begin
            commit  = (state == WAIT) && (cnt == 4'd1);
            c_we    = we_q;
            c_strb  = wstrb_q;
            c_idx   = idx_q;
            c_wdata = wdata_q;
            c_err   = err_q;
        end
    end

    assign ram_we = (commit && c_we && !c_err) ? c_strb : 4'b0000;
    assign ram_re = commit && !c_we;

    dmem_byte_ram #(
        .IDX_W (IdxW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .idx   (c_idx),
        .wdata (c_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_load_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            wstrb_q     <= 4'b0000;
            idx_q       <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        we_q        <= bus.req_we;
                        wstrb_q     <= bus.req_wstrb;
                        idx_q       <= bus.req_addr[DM_ADDRESS-1:2];
                        wdata_q     <= bus.req_wdata;
                        err_q       <= acc_err;
                        cnt         <= WaitInit;
                        req_ready_q <= 1'b0;
                        if (Direct) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_load_q  <= !c_we;
                            rsp_err_q   <= c_err;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_load_q  <= !c_we;
                        rsp_err_q   <= c_err;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_load_q  <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_load_q ? ram_rdata : '0;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: transaction-level memory model checked every cycle,
// directed scenarios with literal expectations, and a WAIT_STATES=0 timing check.
module tb_dmem_responder;

    localparam int WS = 1;
    localparam int NW = 128;
`ifdef DMEM_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus1 ();
    dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus0 ();

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_STATES(WS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_STATES(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction-level model: memory as bytes plus a "known" map for never-written bytes.
    logic [7:0]  mem_b [NW][4];
    bit          known [NW][4];
    bit          m_rdy  = 1'b0;
    bit          m_busy = 1'b0;
    int          m_age  = 0;
    bit          m_we;
    logic [3:0]  m_strb;
    int          m_idx;
    logic [31:0] m_wd;
    bit          m_err;
    logic [31:0] m_rd;
    logic [31:0] m_mask;

    function automatic bit legal(input logic [3:0] s);
        return s inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    endfunction

    task automatic m_commit();
        if (m_we) begin
            for (int l = 0; l < 4; l++) begin
                if (!m_err && m_strb[l]) begin
                    mem_b[m_idx][l] = m_wd[8*l +: 8];
                    known[m_idx][l] = 1'b1;
                end
            end
            m_rd   = 32'h0;
            m_mask = 32'hFFFF_FFFF;
        end else begin
            for (int l = 0; l < 4; l++) begin
                m_rd[8*l +: 8]   = mem_b[m_idx][l];
                m_mask[8*l +: 8] = known[m_idx][l] ? 8'hFF : 8'h00;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_rdy  = 1'b0;
            m_busy = 1'b0;
            m_age  = 0;
        end else if (!m_busy) begin
            if (bus1.req_valid && m_rdy) begin
                m_we   = bus1.req_we;
                m_strb = bus1.req_wstrb;
                m_idx  = int'(bus1.req_addr[8:2]);
                m_wd   = bus1.req_wdata;
                m_err  = ErrEn && m_we && !legal(m_strb);
                m_busy = 1'b1;
                m_age  = 0;
                m_rdy  = 1'b0;
                if (WS == 0) m_commit();
            end else begin
                m_rdy = 1'b1;
            end
        end else if (m_age >= WS && bus1.rsp_ready) begin
            m_busy = 1'b0;
            m_rdy  = 1'b1;
        end else begin
            m_age++;
            if (m_age == WS) m_commit();
        end
    end

    initial forever begin
        logic        ev;
        logic [31:0] msk;
        @(negedge clk);
        ev  = m_busy && (m_age >= WS);
        msk = ev ? m_mask : 32'hFFFF_FFFF;
        chk("cyc_req_ready", bus1.req_ready, m_rdy);
        chk("cyc_rsp_valid", bus1.rsp_valid, ev);
        chk("cyc_rsp_err", bus1.rsp_err, ev && m_err);
        chk("cyc_rsp_rdata", bus1.rsp_rdata & msk, (ev ? m_rd : 32'h0) & msk);
    end

    // Called and returns at a falling edge; hold>0 keeps rsp_ready low that many cycles.
    task automatic xact(input string name, input bit we, input logic [3:0] st,
                        input logic [8:0] a, input logic [31:0] wd, input int hold,
                        input logic [31:0] exp_rd, input logic exp_er, output int lat);
        int n;
        bus1.req_valid = 1'b1;
        bus1.req_we    = we;
        bus1.req_wstrb = st;
        bus1.req_addr  = a;
        bus1.req_wdata = wd;
        bus1.rsp_ready = (hold == 0);
        n = 0;
        while (!bus1.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_accept"}, bus1.req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus1.req_valid = 1'b0;
        bus1.req_we    = 1'($urandom);
        bus1.req_wstrb = 4'($urandom);
        bus1.req_addr  = 9'($urandom);
        bus1.req_wdata = $urandom;
        lat = 1;
        while (!bus1.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_valid"}, bus1.rsp_valid, 1'b1);
        chk({name, "_rdata"}, bus1.rsp_rdata, exp_rd);
        chk({name, "_err"}, bus1.rsp_err, exp_er);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, "_hold_valid"}, bus1.rsp_valid, 1'b1);
            chk({name, "_hold_rdata"}, bus1.rsp_rdata, exp_rd);
            chk({name, "_hold_req_ready"}, bus1.req_ready, 1'b0);
        end
        bus1.rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int e;
        int acc[$];
        int vis[$];
        logic [31:0] rd0[$];

        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_wstrb = 4'h0;
        bus1.req_addr  = 9'h0; bus1.req_wdata = 32'h0; bus1.rsp_ready = 1'b1;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_wstrb = 4'h0;
        bus0.req_addr  = 9'h0; bus0.req_wdata = 32'h0; bus0.rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus1.req_ready, 1'b0);
        chk("rst_rsp_valid", bus1.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", bus1.rsp_rdata, 32'h0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("first_edge_req_ready", bus1.req_ready, 1'b1);

        // Store aborted by reset in WAIT must never land.
        xact("pre10", 1'b1, 4'hF, 9'h010, 32'h0, 0, 32'h0, 1'b0, lat);
        bus1.req_valid = 1'b1; bus1.req_we = 1'b1; bus1.req_wstrb = 4'hF;
        bus1.req_addr  = 9'h010; bus1.req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        bus1.req_valid = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid_in_rst", bus1.rsp_valid, 1'b0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_rsp_valid_after", bus1.rsp_valid, 1'b0);
        xact("ld10", 1'b0, 4'h0, 9'h010, 32'h0, 0, 32'h0, 1'b0, lat);

        xact("sw04", 1'b1, 4'hF, 9'h004, 32'h1234_5678, 0, 32'h0, 1'b0, lat);
        xact("lw04", 1'b0, 4'h0, 9'h004, 32'h0, 0, 32'h1234_5678, 1'b0, lat);
        chk("lw04_latency", lat, 2);

        xact("sw08", 1'b1, 4'hF, 9'h008, 32'h1122_3344, 0, 32'h0, 1'b0, lat);
        xact("sb08", 1'b1, 4'h2, 9'h008, 32'h0000_AA00, 0, 32'h0, 1'b0, lat);
        xact("lw08", 1'b0, 4'h0, 9'h008, 32'h0, 0, 32'h1122_AA44, 1'b0, lat);
        xact("bp08", 1'b0, 4'h0, 9'h008, 32'h0, 5, 32'h1122_AA44, 1'b0, lat);

        xact("sw0c", 1'b1, 4'hF, 9'h00C, 32'hCAFE_F00D, 0, 32'h0, 1'b0, lat);
        xact("s0_0c", 1'b1, 4'h0, 9'h00C, 32'hFFFF_FFFF, 0, 32'h0, ErrEn, lat);
        xact("lw0c_a", 1'b0, 4'h0, 9'h00C, 32'h0, 0, 32'hCAFE_F00D, 1'b0, lat);
        xact("s5_0c", 1'b1, 4'h5, 9'h00C, 32'hFFFF_FFFF, 0, 32'h0, ErrEn, lat);
        xact("lw0c_b", 1'b0, 4'h0, 9'h00C, 32'h0, 0,
             ErrEn ? 32'hCAFE_F00D : 32'hCAFF_F0FF, 1'b0, lat);
        xact("lw0d", 1'b0, 4'h0, 9'h00D, 32'h0, 0,
             ErrEn ? 32'hCAFE_F00D : 32'hCAFF_F0FF, 1'b0, lat);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 700 == 350) begin
                bus1.req_valid = 1'b0;
                #1 rst_n = 1'b0;
                @(negedge clk);
                #1 rst_n = 1'b1;
            end else begin
                bus1.req_valid = 1'($urandom_range(0, 1));
                bus1.req_we    = 1'($urandom);
                bus1.req_wstrb = 4'($urandom);
                bus1.req_addr  = 9'($urandom_range(0, 63));
                bus1.req_wdata = $urandom;
                bus1.rsp_ready = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
        end
        bus1.req_valid = 1'b0;
        bus1.rsp_ready = 1'b1;
        repeat (5) @(negedge clk);

        // WAIT_STATES=0: store then back-to-back loads, accepts every second edge.
        bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_wstrb = 4'hF;
        bus0.req_addr  = 9'h020; bus0.req_wdata = 32'hA5A5_0F0F;
        e = 0;
        for (int k = 0; k < 12; k++) begin
            if (acc.size() > 0 && e >= acc[0]) bus0.req_we = 1'b0;
            if (bus0.rsp_valid) begin
                vis.push_back(e);
                rd0.push_back(bus0.rsp_rdata);
            end
            if (bus0.req_ready) acc.push_back(e + 1);
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        bus0.req_valid = 1'b0;
        chk("ws0_n_accepts", acc.size(), 6);
        chk("ws0_n_responses", vis.size(), 6);
        for (int i = 0; i < acc.size(); i++) chk("ws0_accept_edge", acc[i], 2*i + 1);
        for (int i = 0; i < vis.size(); i++) begin
            chk("ws0_valid_edge", vis[i], 2*i + 1);
            chk("ws0_rdata", rd0[i], (i == 0) ? 32'h0 : 32'hA5A5_0F0F);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
